// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit between a single-access request port and word-addressed data memory
module mem_access_unit #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          DEPTH_WORDS = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        dm_w,
  output logic        dm_r,
  output logic [1:0]  special_store_signal,
  output logic [10:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);

  localparam logic [2:0] OP_W  = 3'd0;
  localparam logic [2:0] OP_HS = 3'd1;
  localparam logic [2:0] OP_HU = 3'd2;
  localparam logic [2:0] OP_BS = 3'd3;
  localparam logic [2:0] OP_BU = 3'd4;

  state_t      state_q, state_d;
  logic        we_q;
  logic [2:0]  op_q;
  logic        err_q;
  logic [10:0] dm_addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic [31:0] off;
  logic        reject;
  logic [31:0] load_ext;

  // Decode the incoming request: offset from the memory base and every reason to refuse it.
  always_comb begin
    off    = addr - BASE_ADDR;
    reject = 1'b0;
    if (op > OP_BU) begin
      reject = 1'b1;
    end
    if ((op == OP_W) && (off[1:0] != 2'b00)) begin
      reject = 1'b1;
    end
    if (((op == OP_HS) || (op == OP_HU)) && off[0]) begin
      reject = 1'b1;
    end
    if ({2'b00, off[31:2]} >= DEPTH_LIM) begin
      reject = 1'b1;
    end
  end

  // Extend the memory word according to the captured load size; memory returns sub-words in the low bits.
  always_comb begin
    load_ext = dm_rdata;
    case (op_q)
      OP_HS:   load_ext = {{16{dm_rdata[15]}}, dm_rdata[15:0]};
      OP_HU:   load_ext = {16'h0000, dm_rdata[15:0]};
      OP_BS:   load_ext = {{24{dm_rdata[7]}}, dm_rdata[7:0]};
      OP_BU:   load_ext = {24'h00_0000, dm_rdata[7:0]};
      default: load_ext = dm_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: rejected requests skip the memory cycle and go straight to the response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = reject ? RESP : ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture and load result; the word index only moves for accepted accesses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      op_q      <= OP_W;
      err_q     <= 1'b0;
      dm_addr_q <= 11'd0;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
    end else begin
      if ((state_q == IDLE) && req) begin
        we_q    <= we;
        op_q    <= op;
        wdata_q <= wdata;
        err_q   <= reject;
        if (!reject) begin
          dm_addr_q <= off[12:2];
        end
      end
      if ((state_q == ACCESS) && !we_q) begin
        rdata_q <= load_ext;
      end
    end
  end

  // Size select seen by memory, only meaningful while the access is on the bus.
  always_comb begin
    special_store_signal = 2'b00;
    if (state_q == ACCESS) begin
      case (op_q)
        OP_HS, OP_HU: special_store_signal = 2'b01;
        OP_BS, OP_BU: special_store_signal = 2'b10;
        default:      special_store_signal = 2'b00;
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == RESP);
  assign err      = (state_q == RESP) && err_q;
  assign dm_r     = (state_q == ACCESS) && !we_q;
  assign dm_w     = (state_q == ACCESS) && we_q;
  assign dm_addr  = dm_addr_q;
  assign dm_wdata = wdata_q;
  assign rdata    = rdata_q;

endmodule
